// File: rtl/i2c_als_responder.sv
// I2C target exposing a system-config register and a coherent 16-bit ambient-light reading.
// SCL/SDA are synchronised and glitch-filtered before any protocol decision is made.
module i2c_als_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h1E,
    parameter int         FILTER_LEN = 3
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_scl,
    input  logic        I_sda,
    output logic        O_sda_oe,
    input  logic [15:0] I_als_data,
    output logic [7:0]  O_sys_cfg,
    output logic        O_busy
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    // Index 0 is SCL, index 1 is SDA
    logic [1:0]    sync1, sync2, filt, prev;
    logic [CW-1:0] run_cnt [2];

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic [7:0]  tx;
    logic [3:0]  ptr;
    logic [15:0] shadow;
    logic [7:0]  sys_cfg;
    logic        sda_oe;
    logic        busy;
    logic [7:0]  rd_byte;
    logic [7:0]  rx_byte;
    logic        scl_rise, scl_fall, start_det, stop_det;

    // A new level is accepted only after FILTER_LEN identical synchronised samples
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            sync1      <= 2'b11;
            sync2      <= 2'b11;
            filt       <= 2'b11;
            prev       <= 2'b11;
            run_cnt[0] <= '0;
            run_cnt[1] <= '0;
        end else begin
            sync1 <= {I_sda, I_scl};
            sync2 <= sync1;
            prev  <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    run_cnt[i] <= '0;
                end else if (run_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync2[i];
                    run_cnt[i] <= '0;
                end else begin
                    run_cnt[i] <= run_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign scl_rise  =  filt[0] & ~prev[0];
    assign scl_fall  = ~filt[0] &  prev[0];
    assign start_det =  filt[0] & ~filt[1] &  prev[1];
    assign stop_det  =  filt[0] &  filt[1] & ~prev[1];
    assign rx_byte   = {shift[6:0], filt[1]};

    // Register 0x0C returns the live value, which is captured into the shadow on the same edge
    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            4'h0:    rd_byte = sys_cfg;
            4'hC:    rd_byte = I_als_data[7:0];
            4'hD:    rd_byte = shadow[15:8];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= '0;
            ptr     <= '0;
            shadow  <= '0;
            sys_cfg <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            if (scl_rise && (state == ADDR || state == REG || state == WDATA) && bit_cnt != 4'd8) begin
                shift   <= rx_byte;
                bit_cnt <= bit_cnt + 4'd1;
            end
            case (state)
                ADDR: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                        if (shift[7:1] == DEV_ADDR) begin
                            state  <= ADDR_ACK;
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shift[0]) begin
                            tx      <= {rd_byte[6:0], 1'b0};
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 4'd1;
                            state   <= RDATA;
                            if (ptr == 4'hC) shadow <= I_als_data;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= REG;
                        end
                    end
                end
                REG: begin
                    if (scl_rise && bit_cnt == 4'd7) ptr <= rx_byte[3:0];
                    if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                        sda_oe  <= 1'b1;
                        state   <= REG_ACK;
                    end
                end
                WDATA: begin
                    if (scl_rise && bit_cnt == 4'd7) begin
                        if (ptr == 4'h0) sys_cfg <= (rx_byte == 8'h04) ? 8'h00 : rx_byte;
                        ptr <= ptr + 4'd1;
                    end
                    if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= '0;
                        sda_oe  <= 1'b1;
                        state   <= WDATA_ACK;
                    end
                end
                REG_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WDATA;
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= RDATA_ACK;
                        end else begin
                            sda_oe  <= ~tx[7];
                            tx      <= {tx[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                RDATA_ACK: begin
                    // The pointer advances on the initiator ACK so the next load sees the new address
                    if (scl_rise) begin
                        if (filt[1]) state <= IGNORE;
                        else         ptr   <= ptr + 4'd1;
                    end else if (scl_fall) begin
                        tx      <= {rd_byte[6:0], 1'b0};
                        sda_oe  <= ~rd_byte[7];
                        bit_cnt <= 4'd1;
                        state   <= RDATA;
                        if (ptr == 4'hC) shadow <= I_als_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_sda_oe  = sda_oe;
    assign O_busy    = busy;
    assign O_sys_cfg = sys_cfg;

endmodule

// File: tb/tb_i2c_als_responder.sv
// Directed bench for i2c_als_responder: the bench acts as I2C initiator on a wired-AND SDA line
// and compares ACKs, read data, register and status outputs against hand-computed values.
module tb_i2c_als_responder;

    localparam int T = 16;

    logic        I_clk = 1'b0;
    logic        I_reset;
    logic        I_scl;
    logic        I_sda;
    logic        O_sda_oe;
    logic [15:0] I_als_data;
    logic [7:0]  O_sys_cfg;
    logic        O_busy;
    logic        sda_drv;

    int vectors     = 0;
    int miscompares = 0;

    always #5 I_clk = ~I_clk;

    assign I_sda = sda_drv & ~O_sda_oe;

    i2c_als_responder #(.DEV_ADDR(7'h1E), .FILTER_LEN(3)) dut (
        .I_clk     (I_clk),
        .I_reset   (I_reset),
        .I_scl     (I_scl),
        .I_sda     (I_sda),
        .O_sda_oe  (O_sda_oe),
        .I_als_data(I_als_data),
        .O_sys_cfg (O_sys_cfg),
        .O_busy    (O_busy)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic applyStimulus(input logic scl, input logic sda, input int cycles);
        I_scl   = scl;
        sda_drv = sda;
        repeat (cycles) @(negedge I_clk);
    endtask

    task automatic i2c_start();
        applyStimulus(1'b0, 1'b1, T);
        applyStimulus(1'b1, 1'b1, T);
        applyStimulus(1'b1, 1'b0, T);
        applyStimulus(1'b0, 1'b0, T);
    endtask

    task automatic i2c_stop();
        applyStimulus(1'b0, 1'b0, T);
        applyStimulus(1'b1, 1'b0, T);
        applyStimulus(1'b1, 1'b1, T);
    endtask

    task automatic write_bit(input logic b);
        applyStimulus(1'b0, b, T);
        applyStimulus(1'b1, b, 2 * T);
        applyStimulus(1'b0, b, T);
    endtask

    // Single-cycle SDA flip while SCL is high, plus one-cycle SCL pulses in both phases
    task automatic glitch_bit(input logic b);
        applyStimulus(1'b0, b, T);
        applyStimulus(1'b1, b, 4);
        applyStimulus(1'b1, ~b, 1);
        applyStimulus(1'b1, b, 4);
        applyStimulus(1'b0, b, 1);
        applyStimulus(1'b1, b, 2 * T - 9);
        applyStimulus(1'b0, b, 4);
        applyStimulus(1'b1, b, 1);
        applyStimulus(1'b0, b, T - 5);
    endtask

    task automatic read_bit(output logic b);
        applyStimulus(1'b0, 1'b1, T);
        applyStimulus(1'b1, 1'b1, T);
        b = I_sda;
        applyStimulus(1'b1, 1'b1, T);
        applyStimulus(1'b0, 1'b1, T);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            if (glitch) glitch_bit(d[i]);
            else        write_bit(d[i]);
        end
        read_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic send_ack);
        logic b;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~send_ack);
    endtask

    // Sends an address byte and measures cycles from the 8th pad SCL fall to the ACK drive
    task automatic addr_byte_timed(input logic [7:0] d, output int latency, output logic acked);
        logic b;
        for (int i = 7; i >= 1; i--) write_bit(d[i]);
        applyStimulus(1'b0, d[0], T);
        applyStimulus(1'b1, d[0], 2 * T);
        I_scl   = 1'b0;
        latency = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge I_clk);
            #1;
            latency++;
            if (O_sda_oe) break;
        end
        applyStimulus(1'b0, d[0], T);
        read_bit(b);
        acked = ~b;
    endtask

    initial begin
        logic       ack;
        logic [7:0] data;
        int         lat;

        I_reset    = 1'b1;
        I_scl      = 1'b1;
        sda_drv    = 1'b1;
        I_als_data = 16'hABCD;
        repeat (5) @(negedge I_clk);
        checkOutput("reset_sda_oe", O_sda_oe, 0);
        checkOutput("reset_busy", O_busy, 0);
        checkOutput("reset_sys_cfg", O_sys_cfg, 8'h00);
        I_reset = 1'b0;
        repeat (10) @(negedge I_clk);

        // Basic write of sys_cfg, including ACK latency measurement
        i2c_start();
        addr_byte_timed(8'h3C, lat, ack);
        checkOutput("wr_addr_ack", ack, 1);
        checkOutput("ack_latency", lat, 6);
        checkOutput("wr_busy", O_busy, 1);
        write_byte(8'h00, 1'b0, ack);
        checkOutput("wr_reg_ack", ack, 1);
        write_byte(8'h01, 1'b0, ack);
        checkOutput("wr_data_ack", ack, 1);
        i2c_stop();
        checkOutput("wr_sys_cfg", O_sys_cfg, 8'h01);
        checkOutput("wr_busy_after_stop", O_busy, 0);

        // Coherent 16-bit ALS read through a repeated START
        i2c_start();
        write_byte(8'h3C, 1'b0, ack);
        checkOutput("als_addr_w_ack", ack, 1);
        write_byte(8'h0C, 1'b0, ack);
        checkOutput("als_reg_ack", ack, 1);
        i2c_start();
        write_byte(8'h3D, 1'b0, ack);
        checkOutput("als_addr_r_ack", ack, 1);
        read_byte(data, 1'b1);
        checkOutput("als_low", data, 8'hCD);
        I_als_data = 16'h1234;
        read_byte(data, 1'b0);
        checkOutput("als_high", data, 8'hAB);
        checkOutput("als_busy", O_busy, 1);
        i2c_stop();

        // Foreign address is ignored
        i2c_start();
        write_byte(8'h3E, 1'b0, ack);
        checkOutput("bad_addr_nack", ack, 0);
        checkOutput("bad_addr_busy", O_busy, 0);
        write_byte(8'h55, 1'b0, ack);
        checkOutput("bad_addr_data_nack", ack, 0);
        i2c_stop();
        checkOutput("bad_addr_sys_cfg", O_sys_cfg, 8'h01);

        // Pointer wrap 0xF -> 0x0 during a read
        i2c_start();
        write_byte(8'h3C, 1'b0, ack);
        write_byte(8'h0F, 1'b0, ack);
        checkOutput("wrap_reg_ack", ack, 1);
        i2c_start();
        write_byte(8'h3D, 1'b0, ack);
        read_byte(data, 1'b1);
        checkOutput("wrap_reg_f", data, 8'h00);
        read_byte(data, 1'b0);
        checkOutput("wrap_reg_0", data, 8'h01);
        i2c_stop();

        // Glitched data byte must still be received, with no false START/STOP
        i2c_start();
        write_byte(8'h3C, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        write_byte(8'h37, 1'b1, ack);
        checkOutput("glitch_ack", ack, 1);
        checkOutput("glitch_sys_cfg", O_sys_cfg, 8'h37);
        checkOutput("glitch_busy", O_busy, 1);
        i2c_stop();

        // Reset while the target is pulling SDA low for a 0 data bit (pointer is now 1)
        i2c_start();
        write_byte(8'h3D, 1'b0, ack);
        checkOutput("rst_addr_ack", ack, 1);
        checkOutput("rst_driving_zero", O_sda_oe, 1);
        @(negedge I_clk);
        I_reset = 1'b1;
        @(posedge I_clk);
        #1;
        checkOutput("rst_sda_released", O_sda_oe, 0);
        checkOutput("rst_busy", O_busy, 0);
        checkOutput("rst_sys_cfg", O_sys_cfg, 8'h00);
        repeat (3) @(negedge I_clk);
        I_reset = 1'b0;
        read_byte(data, 1'b0);
        checkOutput("rst_ignores_bus", data, 8'hFF);
        checkOutput("rst_busy_after", O_busy, 0);
        i2c_stop();

        // Soft-reset value 0x04 clears sys_cfg instead of being stored
        i2c_start();
        write_byte(8'h3C, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        write_byte(8'h55, 1'b0, ack);
        i2c_stop();
        checkOutput("soft_pre", O_sys_cfg, 8'h55);
        i2c_start();
        write_byte(8'h3C, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        write_byte(8'h04, 1'b0, ack);
        checkOutput("soft_ack", ack, 1);
        i2c_stop();
        checkOutput("soft_sys_cfg", O_sys_cfg, 8'h00);

        repeat (10) @(negedge I_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
